// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit. Single-outstanding req/ack data bus with store
//            lane steering, load extraction/extension and fault reporting.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_we,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_done,
    output logic [XLEN-1:0] o_rdata,
    output logic [1:0]      o_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_be,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    logic [1:0]      state;
    logic [7:0]      cnt;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      err_q;

    logic            illegal;
    logic            misaligned;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_val;
    logic [8:0]      cnt_inc;
    logic            tmo_hit;

    // Request decode on the raw execute inputs, captured at acceptance.
    always_comb begin
        illegal    = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                     (i_we && i_funct3[2]);
        misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        case (i_funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << i_addr[1:0];
                wdata_n = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << i_addr[1:0];
                wdata_n = {2{i_wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = i_wdata;
            end
        endcase
    end

    always_comb begin
        shifted = i_mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign tmo_hit = (cnt_inc == 9'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        cnt     <= 8'd0;
                        we_q    <= i_we;
                        f3_q    <= i_funct3;
                        off_q   <= i_addr[1:0];
                        addr_q  <= {i_addr[XLEN-1:2], 2'b00};
                        wdata_q <= wdata_n;
                        be_q    <= be_n;
                        if (illegal) begin
                            err_q   <= ERR_ILL;
                            rdata_q <= '0;
                            state   <= RESP;
                        end else if (misaligned) begin
                            err_q   <= ERR_MIS;
                            rdata_q <= '0;
                            state   <= RESP;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (i_mem_ack) begin
                        rdata_q <= we_q ? '0 : load_val;
                        err_q   <= ERR_OK;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt_inc[7:0];
                        if (tmo_hit) begin
                            rdata_q <= '0;
                            err_q   <= ERR_TMO;
                            state   <= RESP;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready     = (state == IDLE);
    assign o_done      = (state == RESP);
    assign o_mem_req   = (state == REQ);
    assign o_mem_we    = we_q && (state == REQ);
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_be    = be_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

endmodule
`default_nettype wire
